aes_key_unroll: RTL
===================

# aes_key_unroll

Iterative AES-128 decryption key scheduler. It takes the cipher key and expands it forward to the round-10 key in 10 cycles. It then streams round keys in reverse order (10 down to 0) over a valid/ready handshake, stepping the inverse key recurrence one round per accepted key. It sits between key load and the inverse-cipher round datapath, so decryption does not need an 1408-bit stored schedule.

## Interface
- AUTO_WRAP, 1, 1: after round 0 is accepted, reload the saved round-10 key and keep emitting; 0: return to IDLE.
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; asynchronous, active-high
- start  in  1  load key and begin forward expansion (single-cycle pulse)
- key  in  128  cipher key, sampled when start=1; bits [127:96] = w[0], first byte in MSBs
- key_ready  in  1  consumer accepts the current round_key
- key_valid  out  1  round_key/round_idx valid
- round_key  out  128  round key for round_idx; bits [127:96] = w[4r]
- round_idx  out  4  round number of round_key, 10..0
- busy  out  1  forward expansion in progress

## Operation
- Registers:
  - work[127:0], the current round key.
  - last[127:0], the saved round-10 key.
  - cnt[3:0].
  - state ∈ {IDLE, EXPAND, EMIT}.
- Forward step, producing round r from the current words w0..w3:
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]
  - n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
- Inverse step, producing round r-1 from round r:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[r]
- RotWord is a left byte rotate. Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in byte [31:24].
- One shared SubWord instance. A mux selects w3 (EXPAND) or p3 (EMIT) as its input.
- IDLE:
  - key_valid=0.
  - start: work←key, cnt←1, go to EXPAND.
- EXPAND:
  - Each cycle: work←forward(work, cnt), cnt←cnt+1.
  - On the cycle with cnt=10: also last←forward result, cnt←10, go to EMIT.
- EMIT:
  - key_valid=1, round_key=work, round_idx=cnt.
  - On key_valid&&key_ready with cnt>0: work←inverse(work, cnt), cnt←cnt-1.
  - On accept with cnt=0 and AUTO_WRAP=1: work←last, cnt←10, stay in EMIT.
  - On accept with cnt=0 and AUTO_WRAP=0: go to IDLE.
- start in any state has priority: it restarts EXPAND with the new key and drops key_valid the next cycle. No partial output is produced.
- key_ready while key_valid=0 is ignored.
- round_key and round_idx are held stable while key_valid=1 and key_ready=0.

## Timing
- Reset values:
  - state=IDLE, key_valid=0, busy=0.
  - round_key=0, round_idx=0.
  - work, last and cnt cleared.
- Reset asserted mid-EXPAND or mid-EMIT aborts immediately, asynchronously. The next start is required.
- Latency: start sampled at edge T → busy=1 after T through the edge at T+10 → key_valid=1 with round 10 after edge T+10.
- Throughput: one key per cycle while key_ready=1. Rounds 10..0 take 11 consecutive accepting cycles.
- Wrap (AUTO_WRAP=1): round 10 reappears the cycle after round 0 is accepted, with no bubble.
- All outputs are registered or decoded from state and cnt only. There is no combinational path from key_ready to outputs.

## Structure
- Shared aes_pkg holds:
  - constants NR=10 and NK=4;
  - function rcon(r) returning 8 bits;
  - the state enum {IDLE, EXPAND, EMIT}.
- Sub-modules:
  - Instantiate the existing SubWord (four SubBytes) once; no new S-box.
  - RotWord is inline wiring.
- Target size: about 150–200 lines.

## Test plan
- Forward expansion: key 2b7e151628aed2a6abf7158809cf4f3c, start, key_ready=0.
  - busy high for 10 cycles.
  - Then key_valid=1, round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, held for 20 cycles.
- Reverse stream: same key, key_ready=1.
  - idx 9 = ac7766f319fadc2128d12941575c006e.
  - idx 1 = a0fafe1788542cb123a339392a6c7605.
  - idx 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Then idx 10 again (AUTO_WRAP=1). With AUTO_WRAP=0: key_valid=0 and IDLE instead.
- Random key_ready backpressure over 3 full wraps: every accepted key matches a software schedule, and no round is skipped or repeated.
- start at cnt=6 in EMIT with key 000102030405060708090a0b0c0d0e0f:
  - key_valid drops the next cycle;
  - after 10 cycles round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- rst pulse mid-EXPAND (cycle 4) and mid-EMIT:
  - all outputs 0 asynchronously;
  - no key_valid until a new start, then the correct round-10 key 10 cycles later.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round/key sizes, round constants and
// the scheduler state encoding.
package aes_pkg;

   localparam int NR = 10;   // rounds for AES-128
   localparam int NK = 4;    // 32-bit words per cipher key

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      EMIT   = 2'd2
   } state_t;

   // Round constant for round r (1..10); rounds outside that range get 0.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_key_unroll_subword.sv
// SubWord: the AES S-box applied independently to each byte of a 32-bit word.
module aes_key_unroll_subword (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry x sits at bit offset (255 - x) * 8, and 255 - x is simply ~x.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                    sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_unroll.sv
// Iterative AES-128 decryption key scheduler. Expands the cipher key forward
// to round 10 (one round per cycle), then streams round keys 10..0 over a
// valid/ready handshake by running the key recurrence backwards, so no full
// schedule is ever stored. A single SubWord is shared by both directions.
module aes_key_unroll
   import aes_pkg::*;
#(
   parameter bit AUTO_WRAP = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic         key_ready,
   output logic         key_valid,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         busy
);

   localparam int unsigned KEY_W    = 32 * NK;
   localparam logic [3:0]  LAST_RND = 4'(NR);

   state_t           state_q, state_d;
   logic [KEY_W-1:0] work_q, work_d;
   logic [KEY_W-1:0] last_q, last_d;
   logic [3:0]       cnt_q, cnt_d;

   logic [31:0]      w0, w1, w2, w3;
   logic [31:0]      p1, p2, p3;
   logic [31:0]      sub_sel, sub_in, sub_out, rc_word;
   logic [31:0]      f0, f1, f2, f3, i0;
   logic [KEY_W-1:0] fwd_key, inv_key;

   assign w0 = work_q[127:96];
   assign w1 = work_q[95:64];
   assign w2 = work_q[63:32];
   assign w3 = work_q[31:0];

   // Inverse recurrence recovers words 1..3 of the previous round by XOR alone.
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;

   // The shared S-box sees w3 while expanding and p3 while streaming; RotWord
   // is applied after the mux so only one rotation is wired.
   assign sub_sel = (state_q == EMIT) ? p3 : w3;
   assign sub_in  = {sub_sel[23:0], sub_sel[31:24]};
   assign rc_word = {rcon(cnt_q), 24'h000000};

   aes_key_unroll_subword u_subword (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   assign f0 = w0 ^ sub_out ^ rc_word;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign fwd_key = {f0, f1, f2, f3};

   assign i0 = w0 ^ sub_out ^ rc_word;
   assign inv_key = {i0, p1, p2, p3};

   // Next-state: start always wins; otherwise expand or step the reverse stream.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (start) begin
         work_d  = key;
         cnt_d   = 4'd1;
         state_d = EXPAND;
      end else begin
         case (state_q)
            EXPAND: begin
               work_d = fwd_key;
               if (cnt_q == LAST_RND) begin
                  last_d  = fwd_key;
                  cnt_d   = LAST_RND;
                  state_d = EMIT;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            EMIT: begin
               if (key_ready) begin
                  if (cnt_q != 4'd0) begin
                     work_d = inv_key;
                     cnt_d  = cnt_q - 4'd1;
                  end else if (AUTO_WRAP) begin
                     work_d = last_q;
                     cnt_d  = LAST_RND;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and key registers; reset aborts any expansion or stream at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode only from registered state, never from key_ready.
   assign key_valid = (state_q == EMIT);
   assign busy      = (state_q == EXPAND);
   assign round_key = key_valid ? work_q : '0;
   assign round_idx = key_valid ? cnt_q : 4'd0;

endmodule
